timer_share_arb: RTL and testbench
==================================

TIMER_SHARE_ARB -- requirements
Module: timer_share_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter CW, default 10, counter width in bits.
REQ-003 SHALL have parameter MAX_LEN, default 999, largest accepted terminal count.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port req  input  N_REQ  per-requester request for one timed interval; level-held.
REQ-007 SHALL have port len  input  N_REQ*CW  packed terminal counts; slice i = len[i*CW +: CW] belongs to requester i.
REQ-008 SHALL have port gnt  output  N_REQ  one-hot (or zero) current owner of the shared counter.
REQ-009 SHALL have port done  output  N_REQ  one-cycle completion pulse to the owner.
REQ-010 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-011 SHALL have port q  output  CW  current count of the shared counter.

Function
REQ-012 SHALL implement states IDLE, RUN and DONE; all outputs registered.
REQ-013 IDLE, req != 0 at an edge: SHALL pick a winner round-robin, starting at rr_ptr and ascending modulo N_REQ; SHALL go to RUN with gnt[winner]=1, q=0, len_l = min(len slice, MAX_LEN).
REQ-014 IDLE, req == 0: SHALL stay in IDLE with gnt=0, q=0.
REQ-015 RUN, req[owner]=1 and q != len_l: SHALL increment q by 1; no wrap is possible because len_l <= MAX_LEN.
REQ-016 RUN, req[owner]=1 and q == len_l: SHALL go to DONE with gnt=0, done[owner]=1, q=0, rr_ptr = (owner+1) mod N_REQ.
REQ-017 Each grant SHALL therefore hold gnt high for exactly len_l+1 cycles, with q taking values 0..len_l.
REQ-018 RUN, req[owner]=0 (abort): SHALL go to IDLE with gnt=0, q=0, no done, and rr_ptr = (owner+1) mod N_REQ; abort takes priority over terminal count.
REQ-019 DONE SHALL last exactly one cycle, perform no arbitration, clear done, and go to IDLE; the owner drops req in response to done.
REQ-020 Changes to len or to non-owner req bits during RUN SHALL have no effect on the running interval.
REQ-021 Requests from non-owners SHALL stay pending without loss, with no queueing beyond the level-held req.
REQ-022 gnt and done SHALL never be high at the same time, and at most one bit of each SHALL be set.

Reset
REQ-023 reset low SHALL immediately, without a clock edge, force state=IDLE, gnt=0, done=0, busy=0, q=0, len_l=0, rr_ptr=0.
REQ-024 After reset releases, the first arbitration SHALL occur at the first rising edge at which reset is high and req != 0.

Structure
REQ-025 Package timer_share_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default constants CW=10 and MAX_LEN=999.
REQ-026 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs req, rr_ptr; outputs one-hot winner and valid).
REQ-027 The counter, len_l register and FSM SHALL reside in timer_share_arb.

Verification
REQ-028 req=0001, len0=4 -> gnt0 high 5 cycles, q 0,1,2,3,4; done0 high one cycle next; busy high for 6 cycles; then IDLE.
REQ-029 req=0001, len0=999 -> 1000 gnt cycles, q peaks at 999 with no wrap; repeat with len0=1023 -> clamped, identical 1000-cycle result.
REQ-030 req=1111 held, all len=0, each requester drops req on its done -> grant order 0,1,2,3; each grant is 1 gnt cycle, 1 done cycle and 1 IDLE cycle.
REQ-031 req=0010, len1=10, drop req1 when q=3 -> gnt1 cleared at the next edge, no done1 pulse, next grant goes to requester 2 if pending.
REQ-032 Assert reset low mid-RUN at q=500 -> q=0 and gnt=0 before the next clock edge; after release, req=0100 is granted first.
REQ-033 Change len0 from 4 to 50 during RUN -> interval still ends at q=4.

Source files
------------

// File: rtl/timer_share_pkg.sv
// Shared types and default constants for the time-shared interval counter.
package timer_share_pkg;

    localparam int unsigned DefCw     = 10;
    localparam int unsigned DefMaxLen = 999;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after i_rr_ptr, ascending modulo N_REQ.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_rr_ptr,
    output logic [N_REQ-1:0] o_winner,
    output logic             o_valid
);

    logic [IW-1:0] w_idx;

    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        w_idx    = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            w_idx = IW'((int'(i_rr_ptr) + k) % int'(N_REQ));
            if (!o_valid && i_req[w_idx]) begin
                o_winner[w_idx] = 1'b1;
                o_valid         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_share_arb.sv
// One shared up-counter lent round-robin to N_REQ requesters, each for a latched terminal count.
module timer_share_arb
    import timer_share_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned CW      = DefCw,
    parameter int unsigned MAX_LEN = DefMaxLen
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*CW-1:0] len,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    done,
    output logic                busy,
    output logic [CW-1:0]       q
);

    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_e           r_state, w_state_d;
    logic [N_REQ-1:0] r_gnt, w_gnt_d;
    logic [N_REQ-1:0] r_done, w_done_d;
    logic             r_busy, w_busy_d;
    logic [CW-1:0]    r_q, w_q_d;
    logic [CW-1:0]    r_len_l, w_len_l_d;
    logic [IW-1:0]    r_rr_ptr, w_rr_ptr_d;
    logic [IW-1:0]    r_owner, w_owner_d;

    logic [N_REQ-1:0] w_winner;
    logic             w_valid;
    logic [IW-1:0]    w_win_idx;
    logic [CW-1:0]    w_len_arr [N_REQ];
    logic [CW-1:0]    w_len_sel;
    logic [CW-1:0]    w_len_clamp;
    logic [IW-1:0]    w_ptr_next;
    logic [N_REQ-1:0] w_owner_oh;

    for (genvar g = 0; g < N_REQ; g++) begin : g_len_unpack
        assign w_len_arr[g] = len[g*CW +: CW];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr_pick (
        .i_req    (req),
        .i_rr_ptr (r_rr_ptr),
        .o_winner (w_winner),
        .o_valid  (w_valid)
    );

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (w_winner[i]) begin
                w_win_idx = IW'(i);
            end
        end
    end

    assign w_len_sel   = w_len_arr[w_win_idx];
    // Clamping at latch time is what guarantees q can never wrap.
    assign w_len_clamp = (32'(w_len_sel) > MAX_LEN) ? CW'(MAX_LEN) : w_len_sel;
    assign w_ptr_next  = IW'((int'(r_owner) + 1) % int'(N_REQ));
    assign w_owner_oh  = N_REQ'(1) << r_owner;

    always_comb begin
        w_state_d  = r_state;
        w_gnt_d    = r_gnt;
        w_done_d   = '0;
        w_q_d      = r_q;
        w_len_l_d  = r_len_l;
        w_rr_ptr_d = r_rr_ptr;
        w_owner_d  = r_owner;
        unique case (r_state)
            StIdle: begin
                w_gnt_d = '0;
                w_q_d   = '0;
                if (w_valid) begin
                    w_state_d = StRun;
                    w_gnt_d   = w_winner;
                    w_owner_d = w_win_idx;
                    w_len_l_d = w_len_clamp;
                end
            end
            StRun: begin
                // Abort wins over terminal count.
                if (!req[r_owner]) begin
                    w_state_d  = StIdle;
                    w_gnt_d    = '0;
                    w_q_d      = '0;
                    w_rr_ptr_d = w_ptr_next;
                end else if (r_q == r_len_l) begin
                    w_state_d  = StDone;
                    w_gnt_d    = '0;
                    w_done_d   = w_owner_oh;
                    w_q_d      = '0;
                    w_rr_ptr_d = w_ptr_next;
                end else begin
                    w_q_d = r_q + CW'(1);
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
                w_gnt_d   = '0;
                w_q_d     = '0;
            end
        endcase
        w_busy_d = (w_state_d != StIdle);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= StIdle;
            r_gnt    <= '0;
            r_done   <= '0;
            r_busy   <= 1'b0;
            r_q      <= '0;
            r_len_l  <= '0;
            r_rr_ptr <= '0;
            r_owner  <= '0;
        end else begin
            r_state  <= w_state_d;
            r_gnt    <= w_gnt_d;
            r_done   <= w_done_d;
            r_busy   <= w_busy_d;
            r_q      <= w_q_d;
            r_len_l  <= w_len_l_d;
            r_rr_ptr <= w_rr_ptr_d;
            r_owner  <= w_owner_d;
        end
    end

    assign gnt  = r_gnt;
    assign done = r_done;
    assign busy = r_busy;
    assign q    = r_q;

endmodule

// File: tb/tb_timer_share_arb.sv
// Directed and randomized checks of timer_share_arb against an interval-level reference model.
module tb_timer_share_arb;

    localparam int N    = 4;
    localparam int CW   = 10;
    localparam int MAXL = 999;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic [N-1:0]  req   = '0;
    logic [CW-1:0] tb_len [N];
    logic [N*CW-1:0] len;
    logic [N-1:0]  gnt;
    logic [N-1:0]  done;
    logic          busy;
    logic [CW-1:0] q;

    assign len = {tb_len[3], tb_len[2], tb_len[1], tb_len[0]};

    timer_share_arb #(
        .N_REQ   (N),
        .CW      (CW),
        .MAX_LEN (MAXL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .len   (len),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .q     (q)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: who holds the counter (-1 none), how far it has counted, its latched
    // limit, whose turn is next, and who is being told "done" this cycle (-1 none).
    int m_owner, m_cnt, m_lim, m_ptr, m_done;
    bit auto_drop;
    int g_cycles, b_cycles, qmax, n_ticks;

    function automatic void model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_lim   = 0;
        m_ptr   = 0;
        m_done  = -1;
    endfunction

    function automatic void model_step();
        bit found;
        int c;
        found = 1'b0;
        if (m_done >= 0) begin
            m_done = -1;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (!found && req[c]) begin
                    found   = 1'b1;
                    m_owner = c;
                    m_cnt   = 0;
                    m_lim   = (int'(tb_len[c]) > MAXL) ? MAXL : int'(tb_len[c]);
                end
            end
        end else if (!req[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_cnt   = 0;
        end else if (m_cnt == m_lim) begin
            m_done  = m_owner;
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_cnt   = 0;
        end else begin
            m_cnt++;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        g_cycles = 0;
        b_cycles = 0;
        qmax     = 0;
        n_ticks  = 0;
    endtask

    task automatic tick();
        logic [N-1:0] eg;
        logic [N-1:0] ed;
        @(posedge clk);
        model_step();
        #1;
        eg = '0;
        ed = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        if (m_done >= 0) ed[m_done] = 1'b1;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("done", 32'(done), 32'(ed));
        chk("busy", 32'(busy), 32'(m_owner >= 0 || m_done >= 0));
        chk("q", 32'(q), (m_owner >= 0) ? m_cnt : 0);
        n_ticks++;
        if (gnt != '0) g_cycles++;
        if (busy) b_cycles++;
        if (int'(q) > qmax) qmax = int'(q);
        if (auto_drop && m_done >= 0) req[m_done] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_q", 32'(q), 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_until_idle(input int limit);
        for (int i = 0; i < limit; i++) begin
            tick();
            if (m_owner < 0 && m_done < 0 && req == '0) break;
        end
        chk("idle_reached", 32'(m_owner < 0 && m_done < 0), 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int order [$];
        logic [N-1:0] prev_gnt;
        for (int i = 0; i < N; i++) tb_len[i] = '0;
        model_reset();
        auto_drop = 1'b1;

        // Single interval of length 4.
        do_reset();
        tb_len[0] = 10'd4;
        req = 4'b0001;
        clear_stats();
        run_until_idle(20);
        chk("t028_gnt_cycles", g_cycles, 5);
        chk("t028_busy_cycles", b_cycles, 6);
        chk("t028_qmax", qmax, 4);

        // Full-range interval, then an over-range length that must clamp.
        tb_len[0] = 10'd999;
        req = 4'b0001;
        clear_stats();
        run_until_idle(1100);
        chk("t029_gnt_cycles_999", g_cycles, 1000);
        chk("t029_qmax_999", qmax, 999);
        tb_len[0] = 10'd1023;
        req = 4'b0001;
        clear_stats();
        run_until_idle(1100);
        chk("t029_gnt_cycles_1023", g_cycles, 1000);
        chk("t029_qmax_1023", qmax, 999);

        // All four requesting zero-length intervals: fair rotation.
        do_reset();
        for (int i = 0; i < N; i++) tb_len[i] = '0;
        req = 4'b1111;
        clear_stats();
        prev_gnt = '0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (gnt != '0 && prev_gnt == '0) begin
                for (int b = 0; b < N; b++) if (gnt[b]) order.push_back(b);
            end
            prev_gnt = gnt;
            if (m_owner < 0 && m_done < 0 && req == '0) break;
        end
        chk("t030_n_grants", order.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t030_order", (i < order.size()) ? order[i] : -1, i);
        end
        chk("t030_total_cycles", n_ticks, 12);

        // Abort mid-interval; the next pending requester gets the counter.
        do_reset();
        tb_len[1] = 10'd10;
        tb_len[2] = 10'd2;
        req = 4'b0110;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (m_owner == 1 && m_cnt == 3) break;
        end
        chk("t031_q_at_drop", 32'(q), 3);
        req[1] = 1'b0;
        tick();
        chk("t031_gnt_after_abort", 32'(gnt), 0);
        chk("t031_no_done", 32'(done), 0);
        tick();
        chk("t031_next_owner", 32'(gnt), 32'(4'b0100));
        run_until_idle(20);

        // Asynchronous reset in the middle of a long interval.
        do_reset();
        tb_len[0] = 10'd999;
        tb_len[2] = 10'd3;
        req = 4'b0001;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (m_owner == 0 && m_cnt == 500) break;
        end
        chk("t032_q_before_reset", 32'(q), 500);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("t032_async_q", 32'(q), 0);
        chk("t032_async_gnt", 32'(gnt), 0);
        chk("t032_async_busy", 32'(busy), 0);
        req = 4'b0100;
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("t032_first_grant", 32'(gnt), 32'(4'b0100));
        run_until_idle(20);

        // Length change during an interval is ignored.
        do_reset();
        tb_len[0] = 10'd4;
        req = 4'b0001;
        clear_stats();
        tick();
        tick();
        tb_len[0] = 10'd50;
        run_until_idle(100);
        chk("t033_gnt_cycles", g_cycles, 5);
        chk("t033_qmax", qmax, 4);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < N; i++) tb_len[i] = CW'($urandom_range(0, 12));
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) req[$urandom_range(0, N - 1)] = 1'b1;
            if ($urandom_range(0, 39) == 0) req[$urandom_range(0, N - 1)] = 1'b0;
            if ($urandom_range(0, 9) == 0) tb_len[$urandom_range(0, N - 1)] = CW'($urandom_range(0, 20));
            if ($urandom_range(0, 299) == 0) tb_len[$urandom_range(0, N - 1)] = CW'($urandom_range(990, 1023));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
